// File: rtl/exec_stage_p.sv
// exec_stage_p - parametrised EX pipeline stage.
// Sits between the ID/EX and EX/MEM pipeline registers. Single-cycle ALU,
// load/store address generation, conditional inc/dec, and an iterative
// shift-add multiplier that stalls upstream for XLEN+1 edges.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   id_valid / id_ready      upstream handshake (accept when both high)
//   mem_stall                downstream stall, freezes all EX/MEM outputs
//   fwd_a_sel / fwd_b_sel    operand source: 0,3 IDEX, 1 EXMEMALUOut, 2 MEMWBValue
//   IDEXIR, IDEXA, IDEXB     instruction and register operands
//   MEMWBValue               write-back value for forwarding
//   EXMEMIR, EXMEMALUOut,
//   EXMEMB, ex_valid         registered EX/MEM outputs
//   ex_busy                  multiply in progress
//
// Assumes XLEN > 16 (immediate is sign-extended from IR[15:0]).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting instructions, single-cycle ops complete here
// MUL   | one shift-add step per cycle, counter runs XLEN -> 0
// DONE  | product ready, waits for mem_stall low to register it

module exec_stage_p #(
  parameter int          XLEN       = 32,
  parameter logic [5:0]  OP_ALU     = 6'd0,
  parameter logic [5:0]  OP_LW      = 6'd35,
  parameter logic [5:0]  OP_SW      = 6'd43,
  parameter logic [5:0]  OP_CINDC   = 6'd12,
  parameter logic [5:0]  OP_BEQINIT = 6'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic            mem_stall,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [31:0]     IDEXIR,
  input  logic [XLEN-1:0] IDEXA,
  input  logic [XLEN-1:0] IDEXB,
  input  logic [XLEN-1:0] MEMWBValue,
  output logic [31:0]     EXMEMIR,
  output logic [XLEN-1:0] EXMEMALUOut,
  output logic [XLEN-1:0] EXMEMB,
  output logic            ex_valid,
  output logic            ex_busy
);

  localparam int CW  = $clog2(XLEN + 1);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XLEN_V  = XLEN'(XLEN);
  localparam logic [CW-1:0]   CNT_INI = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  localparam logic [5:0] F_MUL  = 6'd24;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_XOR  = 6'd50;
  localparam logic [5:0] F_NAND = 6'd51;
  localparam logic [5:0] F_SGT  = 6'd52;
  localparam logic [5:0] F_SRL  = 6'd53;
  localparam logic [5:0] F_SLL  = 6'd54;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic [XLEN-1:0] mul_acc;
  logic [31:0]     mul_ir;
  logic [CW-1:0]   mul_cnt;

  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] b_res;
  logic            is_mul;
  logic            shamt_ok;
  logic [5:0]      opcode;
  logic [5:0]      funct;

  assign opcode   = IDEXIR[31:26];
  assign funct    = IDEXIR[5:0];
  assign imm_sext = {{(XLEN-16){IDEXIR[15]}}, IDEXIR[15:0]};
  assign id_ready = (state == IDLE) && !mem_stall;

  always_comb begin
    case (fwd_a_sel)
      2'd1:    a_in = EXMEMALUOut;
      2'd2:    a_in = MEMWBValue;
      default: a_in = IDEXA;
    endcase
    case (fwd_b_sel)
      2'd1:    b_in = EXMEMALUOut;
      2'd2:    b_in = MEMWBValue;
      default: b_in = IDEXB;
    endcase
  end

  // Shift amounts at or beyond the width flush the result to zero.
  assign shamt_ok = (b_in < XLEN_V);

  // Ops that do not produce a result default to holding the registered value.
  always_comb begin
    alu_res = EXMEMALUOut;
    b_res   = EXMEMB;
    is_mul  = 1'b0;
    case (opcode)
      OP_LW, OP_SW: begin
        alu_res = a_in + imm_sext;
        b_res   = b_in;
      end
      OP_ALU: begin
        case (funct)
          F_ADD:  alu_res = a_in + b_in;
          F_SUB:  alu_res = a_in - b_in;
          F_XOR:  alu_res = a_in ^ b_in;
          F_NAND: alu_res = ~(a_in & b_in);
          F_SGT:  alu_res = {{(XLEN-1){1'b0}}, (a_in > b_in)};
          F_SRL:  alu_res = shamt_ok ? (a_in >> b_in[SHW-1:0]) : '0;
          F_SLL:  alu_res = shamt_ok ? (a_in << b_in[SHW-1:0]) : '0;
          F_MUL:  is_mul  = 1'b1;
          default: alu_res = EXMEMALUOut;
        endcase
      end
      OP_CINDC: begin
        alu_res = (a_in != '0) ? (a_in - b_in) : (a_in + b_in);
        b_res   = b_in;
      end
      OP_BEQINIT: alu_res = EXMEMALUOut;
      default:    alu_res = EXMEMALUOut;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      EXMEMIR     <= '0;
      EXMEMALUOut <= '0;
      EXMEMB      <= '0;
      ex_valid    <= 1'b0;
      ex_busy     <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_acc     <= '0;
      mul_ir      <= '0;
      mul_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!mem_stall) begin
            if (id_valid && is_mul) begin
              mul_a    <= a_in;
              mul_b    <= b_in;
              mul_acc  <= '0;
              mul_ir   <= IDEXIR;
              mul_cnt  <= CNT_INI;
              ex_busy  <= 1'b1;
              state    <= MUL;
              EXMEMIR  <= '0;
              ex_valid <= 1'b0;
            end else if (id_valid) begin
              EXMEMIR     <= IDEXIR;
              EXMEMALUOut <= alu_res;
              EXMEMB      <= b_res;
              ex_valid    <= 1'b1;
            end else begin
              EXMEMIR  <= '0;
              ex_valid <= 1'b0;
            end
          end
        end

        MUL: begin
          // Iteration continues under mem_stall; only the outputs freeze.
          if (mul_b[0]) mul_acc <= mul_acc + mul_a;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt - 1'b1;
          if (mul_cnt == CNT_ONE) state <= DONE;
          if (!mem_stall) begin
            EXMEMIR  <= '0;
            ex_valid <= 1'b0;
          end
        end

        DONE: begin
          if (!mem_stall) begin
            EXMEMALUOut <= mul_acc;
            EXMEMIR     <= mul_ir;
            ex_valid    <= 1'b1;
            ex_busy     <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage_p.sv
module tb_exec_stage_p;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic        mem_stall;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] IDEXIR;
  logic [31:0] IDEXA;
  logic [31:0] IDEXB;
  logic [31:0] MEMWBValue;
  logic [31:0] EXMEMIR;
  logic [31:0] EXMEMALUOut;
  logic [31:0] EXMEMB;
  logic        ex_valid;
  logic        ex_busy;

  int n_checks = 0;
  int n_fail   = 0;

  exec_stage_p #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .mem_stall   (mem_stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .IDEXIR      (IDEXIR),
    .IDEXA       (IDEXA),
    .IDEXB       (IDEXB),
    .MEMWBValue  (MEMWBValue),
    .EXMEMIR     (EXMEMIR),
    .EXMEMALUOut (EXMEMALUOut),
    .EXMEMB      (EXMEMB),
    .ex_valid    (ex_valid),
    .ex_busy     (ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wb;
    logic [31:0] exp_alu;
    logic [31:0] exp_b;
    bit          chk_b;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [31:0] rt(input logic [5:0] f);
    return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd4, 5'd5, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] ir,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] wb);
    fwd_a_sel  = fa;
    fwd_b_sel  = fb;
    IDEXIR     = ir;
    IDEXA      = a;
    IDEXB      = b;
    MEMWBValue = wb;
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] wb, input logic [31:0] ea,
                              input logic [31:0] eb, input bit cb);
    vec_t v;
    v.name = nm; v.fa = fa; v.fb = fb; v.ir = ir; v.a = a; v.b = b; v.wb = wb;
    v.exp_alu = ea; v.exp_b = eb; v.chk_b = cb;
    return v;
  endfunction

  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int cnt;
    int bad;
    drive(2'd0, 2'd0, rt(6'd24), a, b, 32'd0);
    id_valid = 1'b1;
    tick;
    chk({nm, "_busy_set"}, {31'd0, ex_busy}, 32'd1);
    // Queued ADD held on the inputs; it must be ignored until the product lands.
    drive(2'd0, 2'd0, rt(6'd32), 32'd1, 32'd1, 32'd0);
    cnt = 0;
    bad = 0;
    while (!id_ready && cnt < 100) begin
      if (ex_valid !== 1'b0 || EXMEMIR !== 32'd0 || ex_busy !== 1'b1) bad++;
      tick;
      cnt++;
    end
    chk({nm, "_ready_low_edges"}, cnt, 32'd33);
    chk({nm, "_bubbles"}, bad, 32'd0);
    chk({nm, "_result"}, EXMEMALUOut, exp);
    chk({nm, "_ir"}, EXMEMIR, rt(6'd24));
    chk({nm, "_valid"}, {31'd0, ex_valid}, 32'd1);
    chk({nm, "_busy_clr"}, {31'd0, ex_busy}, 32'd0);
    tick;
    chk({nm, "_next_add"}, EXMEMALUOut, 32'd2);
    chk({nm, "_next_ir"}, EXMEMIR, rt(6'd32));
    id_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int cnt;

    vecs[0]  = mk("add",        2'd0, 2'd0, rt(6'd32), 32'd5, 32'd7, 32'd0, 32'd12, 32'd0, 1'b0);
    vecs[1]  = mk("add_0x10",   2'd0, 2'd0, rt(6'd32), 32'd8, 32'd8, 32'd0, 32'h10, 32'd0, 1'b0);
    vecs[2]  = mk("sub_fwd",    2'd1, 2'd2, rt(6'd34), 32'd0, 32'd0, 32'd3, 32'hD, 32'd0, 1'b0);
    vecs[3]  = mk("sw_negimm",  2'd0, 2'd2, it(6'd43, 16'hFFFC), 32'h100, 32'h55, 32'h77, 32'hFC, 32'h77, 1'b1);
    vecs[4]  = mk("lw",         2'd0, 2'd0, it(6'd35, 16'h0010), 32'h1000, 32'h9, 32'd0, 32'h1010, 32'h9, 1'b1);
    vecs[5]  = mk("xor",        2'd0, 2'd0, rt(6'd50), 32'hF0F0, 32'hFF00, 32'd0, 32'h0FF0, 32'd0, 1'b0);
    vecs[6]  = mk("nand",       2'd0, 2'd0, rt(6'd51), 32'hFFFFFFFF, 32'h0F0F0F0F, 32'd0, 32'hF0F0F0F0, 32'd0, 1'b0);
    vecs[7]  = mk("sgt_true",   2'd0, 2'd0, rt(6'd52), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 32'd0, 1'b0);
    vecs[8]  = mk("sgt_false",  2'd0, 2'd0, rt(6'd52), 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 1'b0);
    vecs[9]  = mk("srl_31",     2'd0, 2'd0, rt(6'd53), 32'h80000000, 32'd31, 32'd0, 32'd1, 32'd0, 1'b0);
    vecs[10] = mk("srl_32",     2'd0, 2'd0, rt(6'd53), 32'h80000000, 32'd32, 32'd0, 32'd0, 32'd0, 1'b0);
    vecs[11] = mk("sll_4",      2'd0, 2'd0, rt(6'd54), 32'd3, 32'd4, 32'd0, 32'h30, 32'd0, 1'b0);
    vecs[12] = mk("sll_33",     2'd0, 2'd0, rt(6'd54), 32'd1, 32'd33, 32'd0, 32'd0, 32'd0, 1'b0);
    vecs[13] = mk("cindc_zero", 2'd0, 2'd0, it(6'd12, 16'd0), 32'd0, 32'd3, 32'd0, 32'd3, 32'd3, 1'b1);
    vecs[14] = mk("cindc_nz",   2'd0, 2'd0, it(6'd12, 16'd0), 32'd2, 32'd3, 32'd0, 32'hFFFFFFFF, 32'd3, 1'b1);
    vecs[15] = mk("alu_unknown",2'd0, 2'd0, rt(6'd7), 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd3, 1'b1);
    vecs[16] = mk("beqinit",    2'd0, 2'd0, it(6'd4, 16'h1234), 32'd5, 32'd6, 32'd0, 32'hFFFFFFFF, 32'd3, 1'b1);
    vecs[17] = mk("other_op",   2'd0, 2'd0, it(6'd63, 16'h0001), 32'd5, 32'd6, 32'd0, 32'hFFFFFFFF, 32'd3, 1'b1);
    vecs[18] = mk("add_sel3",   2'd3, 2'd3, rt(6'd32), 32'd2, 32'd3, 32'd9, 32'd5, 32'd0, 1'b0);
    vecs[19] = mk("add_fwd_ex", 2'd1, 2'd1, rt(6'd32), 32'd7, 32'd7, 32'd0, 32'd10, 32'd0, 1'b0);
    vecs[20] = mk("sub_wrap",   2'd0, 2'd0, rt(6'd34), 32'd1, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
    vecs[21] = mk("add_wrap",   2'd0, 2'd0, rt(6'd32), 32'hFFFFFFFF, 32'd2, 32'd0, 32'd1, 32'd0, 1'b0);

    rst_n     = 1'b1;
    id_valid  = 1'b0;
    mem_stall = 1'b0;
    drive(2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ir",    EXMEMIR, 32'd0);
    chk("rst_alu",   EXMEMALUOut, 32'd0);
    chk("rst_b",     EXMEMB, 32'd0);
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_busy",  {31'd0, ex_busy}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_ready", {31'd0, id_ready}, 32'd1);

    // Single-cycle vectors, issued back to back.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].fa, vecs[i].fb, vecs[i].ir, vecs[i].a, vecs[i].b, vecs[i].wb);
      id_valid = 1'b1;
      tick;
      chk({vecs[i].name, "_alu"}, EXMEMALUOut, vecs[i].exp_alu);
      chk({vecs[i].name, "_ir"}, EXMEMIR, vecs[i].ir);
      chk({vecs[i].name, "_valid"}, {31'd0, ex_valid}, 32'd1);
      if (vecs[i].chk_b) chk({vecs[i].name, "_b"}, EXMEMB, vecs[i].exp_b);
    end

    // Bubble: no valid instruction.
    id_valid = 1'b0;
    tick;
    chk("bubble_ir",    EXMEMIR, 32'd0);
    chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("bubble_alu",   EXMEMALUOut, 32'd1);

    // mem_stall in IDLE freezes outputs and blocks acceptance.
    drive(2'd0, 2'd0, rt(6'd32), 32'd10, 32'd20, 32'd0);
    id_valid = 1'b1;
    tick;
    chk("pre_stall_add", EXMEMALUOut, 32'd30);
    drive(2'd0, 2'd0, rt(6'd34), 32'd9, 32'd1, 32'd0);
    mem_stall = 1'b1;
    #1;
    chk("stall_ready", {31'd0, id_ready}, 32'd0);
    tick;
    chk("stall_alu",   EXMEMALUOut, 32'd30);
    chk("stall_ir",    EXMEMIR, rt(6'd32));
    chk("stall_valid", {31'd0, ex_valid}, 32'd1);
    mem_stall = 1'b0;
    tick;
    chk("unstall_sub", EXMEMALUOut, 32'd8);
    id_valid = 1'b0;
    tick;

    run_mul("mul_a", 32'h1234, 32'h10, 32'h12340);
    run_mul("mul_b", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

    // Stall while the multiply reaches DONE.
    held = EXMEMALUOut;
    drive(2'd0, 2'd0, rt(6'd24), 32'd3, 32'd5, 32'd0);
    id_valid = 1'b1;
    tick;
    id_valid = 1'b0;
    for (int i = 0; i < 32; i++) tick;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    chk("done_stall_alu",   EXMEMALUOut, held);
    chk("done_stall_valid", {31'd0, ex_valid}, 32'd0);
    chk("done_stall_busy",  {31'd0, ex_busy}, 32'd1);
    chk("done_stall_ready", {31'd0, id_ready}, 32'd0);
    drive(2'd0, 2'd0, rt(6'd32), 32'd10, 32'd20, 32'd0);
    id_valid  = 1'b1;
    mem_stall = 1'b0;
    tick;
    chk("done_release_alu",  EXMEMALUOut, 32'd15);
    chk("done_release_ir",   EXMEMIR, rt(6'd24));
    chk("done_release_busy", {31'd0, ex_busy}, 32'd0);
    tick;
    chk("queued_add", EXMEMALUOut, 32'd30);
    chk("queued_ir",  EXMEMIR, rt(6'd32));
    id_valid = 1'b0;
    tick;

    // Reset in the middle of a multiply.
    drive(2'd0, 2'd0, rt(6'd24), 32'd7, 32'd9, 32'd0);
    id_valid = 1'b1;
    tick;
    id_valid = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      tick;
      cnt++;
    end
    chk("midmul_busy_before", {31'd0, ex_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_alu",   EXMEMALUOut, 32'd0);
    chk("midrst_ir",    EXMEMIR, 32'd0);
    chk("midrst_b",     EXMEMB, 32'd0);
    chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
    chk("midrst_busy",  {31'd0, ex_busy}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("postrst_ready", {31'd0, id_ready}, 32'd1);
    drive(2'd0, 2'd0, rt(6'd32), 32'd4, 32'd5, 32'd0);
    id_valid = 1'b1;
    tick;
    chk("postrst_add",   EXMEMALUOut, 32'd9);
    chk("postrst_valid", {31'd0, ex_valid}, 32'd1);
    id_valid = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
